// File: rtl/timer_device_pkg.sv
// Shared definitions for the memory-mapped countdown timer: FSM state
// encoding, register offsets, CTRL bit layout and mode constants.
package timer_defs;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_COUNT = 2'd2,
        ST_INTR  = 2'd3
    } timer_state_e;

    // Register select values, taken from address[3:2]
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_NONE   = 2'd3;

    // CTRL bit layout; everything above CTRL_BITS reads as zero
    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_MSB = 2;
    localparam int CTRL_MASK_BIT = 3;
    localparam int CTRL_BITS     = 4;

    // Modes 2 and 3 are reserved and behave like one-shot
    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_RELOAD  = 2'd1;

    typedef struct packed {
        logic       irq_mask;
        logic [1:0] mode;
        logic       enable;
    } ctrl_t;

    function automatic ctrl_t ctrl_from_word(input logic [CTRL_BITS-1:0] w);
        ctrl_t c;
        c.enable   = w[CTRL_EN_BIT];
        c.mode     = w[CTRL_MODE_MSB:CTRL_MODE_LSB];
        c.irq_mask = w[CTRL_MASK_BIT];
        return c;
    endfunction

    function automatic logic is_reload(input logic [1:0] mode);
        return mode == MODE_RELOAD;
    endfunction

endpackage

// File: rtl/timer_device_if.sv
// Bridge-side register bus of the timer: word-select address, write
// strobe/data and combinational read data.
interface timer_device_if #(
    parameter int WIDTH = 32
);
    logic [3:0]       address;
    logic [WIDTH-1:0] write_data;
    logic             write_enable;
    logic [WIDTH-1:0] read_data;

    modport master (
        output address,
        output write_data,
        output write_enable,
        input  read_data
    );

    modport slave (
        input  address,
        input  write_data,
        input  write_enable,
        output read_data
    );
endinterface

// File: rtl/timer_register_file.sv
// CTRL/PRESET storage, write decode and combinational read mux for the
// timer. COUNT lives in the FSM and is only muxed in here for reads.
module timer_register_file
    import timer_defs::*;
#(
    parameter int         WIDTH      = 32,
    parameter logic [1:0] RESET_MODE = MODE_ONESHOT
) (
    input  logic             clock,
    input  logic             reset_n,
    timer_device_if.slave    bus,
    input  logic [WIDTH-1:0] count_i,
    input  logic             clr_enable_i,
    output ctrl_t            ctrl_o,
    output logic [WIDTH-1:0] preset_o,
    output logic             ctrl_wr_o,
    output logic             preset_wr_o
);

    ctrl_t            ctrl_q, ctrl_d;
    logic [WIDTH-1:0] preset_q, preset_d;
    logic [WIDTH-1:0] rdata;
    logic [1:0]       sel;
    logic             unused_addr_bits;

    // Byte offset bits [1:0] do not take part in decode
    assign sel              = bus.address[3:2];
    assign unused_addr_bits = ^bus.address[1:0];

    // COUNT and the unused slot are read-only; writes there are dropped
    assign ctrl_wr_o   = bus.write_enable && (sel == REG_CTRL);
    assign preset_wr_o = bus.write_enable && (sel == REG_PRESET);

    assign ctrl_o   = ctrl_q;
    assign preset_o = preset_q;

    // Next-state for CTRL/PRESET; a CPU write to CTRL overrides the FSM's enable clear
    always_comb begin
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        if (clr_enable_i) begin
            ctrl_d.enable = 1'b0;
        end
        if (ctrl_wr_o) begin
            ctrl_d = ctrl_from_word(bus.write_data[CTRL_BITS-1:0]);
        end
        if (preset_wr_o) begin
            preset_d = bus.write_data;
        end
    end

    // Register storage with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ctrl_q   <= '{irq_mask: 1'b0, mode: RESET_MODE, enable: 1'b0};
            preset_q <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
        end
    end

    // Read mux straight from current register contents
    always_comb begin
        rdata = '0;
        case (sel)
            REG_CTRL:   rdata = {{(WIDTH-CTRL_BITS){1'b0}}, ctrl_q};
            REG_PRESET: rdata = preset_q;
            REG_COUNT:  rdata = count_i;
            REG_NONE:   rdata = '0;
            default:    rdata = '0;
        endcase
    end

    assign bus.read_data = rdata;

endmodule

// File: rtl/timer_device.sv
// Memory-mapped countdown timer: load/count/interrupt FSM, the COUNT
// register and the pending-interrupt flag, around the register file.
module timer_device
    import timer_defs::*;
#(
    parameter int         WIDTH      = 32,
    parameter logic [1:0] RESET_MODE = MODE_ONESHOT
) (
    input  logic          clock,
    input  logic          reset_n,
    timer_device_if.slave bus,
    output logic          interrupt_request
);

    timer_state_e     state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             irq_pending_q, irq_pending_d;
    logic             clr_enable;

    ctrl_t            ctrl;
    logic [WIDTH-1:0] preset;
    logic             ctrl_wr;
    logic             preset_wr;
    logic             enable_eff;

    timer_register_file #(
        .WIDTH      (WIDTH),
        .RESET_MODE (RESET_MODE)
    ) u_regs (
        .clock        (clock),
        .reset_n      (reset_n),
        .bus          (bus),
        .count_i      (count_q),
        .clr_enable_i (clr_enable),
        .ctrl_o       (ctrl),
        .preset_o     (preset),
        .ctrl_wr_o    (ctrl_wr),
        .preset_wr_o  (preset_wr)
    );

    // A CTRL write in progress steers the FSM at the same edge it lands, so
    // enabling goes IDLE->LOAD immediately and disabling stops the count at once.
    assign enable_eff = ctrl_wr ? bus.write_data[CTRL_EN_BIT] : ctrl.enable;

    // Next-state, counter and pending-flag logic
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        irq_pending_d = irq_pending_q;
        clr_enable    = 1'b0;

        // Any CTRL/PRESET write acknowledges; an expiry below overrides it
        if (ctrl_wr || preset_wr) begin
            irq_pending_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (enable_eff) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (!enable_eff) begin
                    state_d = ST_IDLE;
                end else begin
                    count_d = preset;
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (!enable_eff) begin
                    state_d = ST_IDLE;
                end else if (count_q > WIDTH'(1)) begin
                    count_d = count_q - WIDTH'(1);
                end else begin
                    // Guarded at 1 so PRESET=0 acts as 1 and the counter never wraps
                    count_d       = '0;
                    irq_pending_d = 1'b1;
                    state_d       = ST_INTR;
                end
            end
            ST_INTR: begin
                if (is_reload(ctrl.mode)) begin
                    irq_pending_d = 1'b0;
                    state_d       = ST_LOAD;
                end else begin
                    clr_enable = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter and pending flag registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            count_q       <= '0;
            irq_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            irq_pending_q <= irq_pending_d;
        end
    end

    // Both operands are flops, so the IRQ line has no path from bus inputs
    assign interrupt_request = irq_pending_q & ctrl.irq_mask;

endmodule
